// File: rtl/ram_n.sv
// ---------------------------------------------------------------------------
// ram_n -- single-port word RAM with a post-reset hardware clear sequence.
//
// After rst_n is released the block walks every word and writes zero, one
// word per clock.  During that time busy is high, the user port is ignored
// and the read data is forced to zero.  Once every word is clear the block
// enters READY and behaves as a plain write-enable RAM.
//
// Build option:
//   RAM_N_REGOUT_EN  defined   -> read data is registered (1-cycle latency,
//                                 read-before-write on a simultaneous write)
//                    undefined -> read data is combinational from the array
//
// Parameters:
//   WIDTH  data word width in bits (>= 1)
//   DEPTH  number of words, power of two, >= 2
//   AW     derived address width, clog2(DEPTH); not overridable
//
// Ports:
//   clk      in   1      single clock, rising edge
//   rst_n    in   1      synchronous active-low reset
//   in       in   WIDTH  write data
//   address  in   AW     read/write word address
//   load     in   1      write enable, active-high
//   out      out  WIDTH  read data (0 while clearing or in reset)
//   busy     out  1      high while the clear sequence runs
// ---------------------------------------------------------------------------
module ram_n #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    address,
    input  logic             load,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e            state_q;
    state_e            state_d;
    logic [AW-1:0]     clr_ptr_q;
    logic [AW-1:0]     clr_ptr_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              mem_we_s;
    logic [AW-1:0]     mem_waddr_s;
    logic [WIDTH-1:0]  mem_wdata_s;
    logic [WIDTH-1:0]  rd_data_s;

    // State and clear-pointer registers; reset parks the block at the start
    // of the clear sequence so a full DEPTH-cycle sweep follows release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= {AW{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next-state logic and write-port steering.  While clearing, the write
    // port belongs to the sweep and the user inputs are ignored entirely.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = address;
        mem_wdata_s = in;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_ptr_q;
                mem_wdata_s = {WIDTH{1'b0}};
                clr_ptr_d   = clr_ptr_q + AW'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: begin
                if (load) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
                state_d = ST_READY;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = {AW{1'b0}};
                mem_we_s  = 1'b0;
            end
        endcase
    end

    // Storage array; no write of any kind happens on an edge with rst_n low,
    // which also drops a user write that coincides with reset.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Raw array read, forced to zero outside READY.
    always_comb begin
        if (state_q == ST_READY) begin
            rd_data_s = mem_q[address];
        end else begin
            rd_data_s = {WIDTH{1'b0}};
        end
    end

`ifdef RAM_N_REGOUT_EN
    logic [WIDTH-1:0] out_q;

    // Registered read: samples the array before any same-edge write lands,
    // so a simultaneous write returns the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= {WIDTH{1'b0}};
        end else if (state_q != ST_READY) begin
            out_q <= {WIDTH{1'b0}};
        end else begin
            out_q <= rd_data_s;
        end
    end

    assign out = out_q;
`else
    // Combinational read: a write becomes visible after its edge.
    assign out = rd_data_s;
`endif

    assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_n.sv
// ---------------------------------------------------------------------------
// tb_ram_n -- directed self-checking bench for ram_n.
// Two instances: WIDTH=16/DEPTH=8 (a_*) and WIDTH=8/DEPTH=32 (b_*).
// Honours RAM_N_REGOUT_EN for the expected read latency.
// ---------------------------------------------------------------------------
module tb_ram_n;

    logic        clk;
    int          n_checks;
    int          n_errors;

    // instance A: 16 x 8
    logic        a_rst_n;
    logic [15:0] a_in;
    logic [2:0]  a_addr;
    logic        a_load;
    logic [15:0] a_out;
    logic        a_busy;

    // instance B: 8 x 32
    logic        b_rst_n;
    logic [7:0]  b_in;
    logic [4:0]  b_addr;
    logic        b_load;
    logic [7:0]  b_out;
    logic        b_busy;

    ram_n #(.WIDTH(16), .DEPTH(8)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .in(a_in), .address(a_addr),
        .load(a_load), .out(a_out), .busy(a_busy)
    );

    ram_n #(.WIDTH(8), .DEPTH(32)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .in(b_in), .address(b_addr),
        .load(b_load), .out(b_out), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are driven 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // count cycles busy stays high from now on, bounded
    task automatic count_busy_a(output int cnt);
        cnt = 0;
        while (a_busy === 1'b1 && cnt < 200) begin
            cnt = cnt + 1;
            tick();
            #1;
        end
    endtask

    task automatic count_busy_b(output int cnt);
        cnt = 0;
        while (b_busy === 1'b1 && cnt < 200) begin
            cnt = cnt + 1;
            tick();
            #1;
        end
    endtask

    task automatic write_a(input logic [2:0] a, input logic [15:0] d);
        a_addr = a;
        a_in   = d;
        a_load = 1'b1;
        tick();
        a_load = 1'b0;
    endtask

    task automatic read_a(input string tag, input logic [2:0] a, input logic [15:0] exp);
        a_addr = a;
`ifdef RAM_N_REGOUT_EN
        tick();
`endif
        #1;
        check(tag, {16'h0, a_out}, {16'h0, exp});
    endtask

    task automatic write_b(input logic [4:0] a, input logic [7:0] d);
        b_addr = a;
        b_in   = d;
        b_load = 1'b1;
        tick();
        b_load = 1'b0;
    endtask

    task automatic read_b(input string tag, input logic [4:0] a, input logic [7:0] exp);
        b_addr = a;
`ifdef RAM_N_REGOUT_EN
        tick();
`endif
        #1;
        check(tag, {24'h0, b_out}, {24'h0, exp});
    endtask

    initial begin
        int cnt;
        logic [7:0] pat;
        n_checks = 0;
        n_errors = 0;
        a_rst_n = 1'b0; a_in = 16'hFFFF; a_addr = 3'd2; a_load = 1'b1;
        b_rst_n = 1'b0; b_in = 8'h00;    b_addr = 5'd0; b_load = 1'b0;

        // reset held 3 cycles with a user write request pending
        for (int i = 0; i < 3; i++) tick();
        #1;
        check("rst_busy", {31'h0, a_busy}, 32'h1);
        check("rst_out", {16'h0, a_out}, 32'h0);

        // release; user write to word 2 stays requested throughout CLEAR
        a_rst_n = 1'b1;
        #1;
        check("clr_out0", {16'h0, a_out}, 32'h0);
        count_busy_a(cnt);
        check("clr_len8", cnt, 32'd8);
        a_load = 1'b0;
        a_in   = 16'h0000;

        // whole array reads zero, including the word targeted during CLEAR
        for (int k = 0; k < 8; k++) read_a("zero_a", 3'(k), 16'h0000);

        // basic writes and reads
        write_a(3'd3, 16'hBEEF);
        write_a(3'd7, 16'h1234);
        read_a("rd3", 3'd3, 16'hBEEF);
        read_a("rd7", 3'd7, 16'h1234);
        read_a("rd5", 3'd5, 16'h0000);

        // read during the write cycle returns the old word
        a_addr = 3'd1;
        a_in   = 16'h00AA;
        a_load = 1'b1;
`ifdef RAM_N_REGOUT_EN
        tick();
        a_load = 1'b0;
        #1;
        check("rbw_old", {16'h0, a_out}, 32'h0);
        tick();
        #1;
        check("rbw_new", {16'h0, a_out}, 32'h00AA);
`else
        #1;
        check("rbw_old", {16'h0, a_out}, 32'h0);
        tick();
        a_load = 1'b0;
        #1;
        check("rbw_new", {16'h0, a_out}, 32'h00AA);
`endif
        read_a("rd3_keep", 3'd3, 16'hBEEF);

        // reset from READY, then pulse reset again in clear cycle 4
        a_rst_n = 1'b0;
        tick();
        #1;
        check("rst2_busy", {31'h0, a_busy}, 32'h1);
        check("rst2_out", {16'h0, a_out}, 32'h0);
        a_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("mid_busy", {31'h0, a_busy}, 32'h1);
        a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
        #1;
        count_busy_a(cnt);
        check("restart_len8", cnt, 32'd8);
        for (int k = 0; k < 8; k++) read_a("zero_a2", 3'(k), 16'h0000);

        // second instance: 8 x 32
        tick();
        tick();
        b_rst_n = 1'b1;
        #1;
        count_busy_b(cnt);
        check("clr_len32", cnt, 32'd32);
        for (int k = 0; k < 32; k++) begin
            pat = 8'(k) ^ 8'hA5;
            write_b(5'(k), pat);
        end
        for (int k = 0; k < 32; k++) begin
            pat = 8'(k) ^ 8'hA5;
            read_b("pat_b", 5'(k), pat);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_n.md
RAM_N -- requirements
Module: ram_n

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of words; power of two, >=2.
REQ-003 Derived localparam AW = clog2(DEPTH); not overridable.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in  input  WIDTH  write data.
REQ-007 address  input  AW  read/write word address.
REQ-008 load  input  1  write enable, active-high.
REQ-009 out  output  WIDTH  read data.
REQ-010 busy  output  1  high while the post-reset clear sequence runs.

Function
REQ-011 Two-state FSM: CLEAR, READY.
REQ-012 CLEAR: internal pointer clr_ptr (AW bits) writes 0 to mem[clr_ptr] on each edge, then increments; on the edge writing word DEPTH-1, go to READY.
REQ-013 CLEAR lasts exactly DEPTH cycles; busy=1 in CLEAR, 0 in READY.
REQ-014 In CLEAR, load, in and address are ignored; no user write occurs.
REQ-015 In CLEAR, out SHALL be 0.
REQ-016 READY write: load=1 at rising edge -> mem[address] <= in; other words unchanged.
REQ-017 READY, load=0: memory unchanged.
REQ-018 READY read, without macro: out = mem[address] combinationally; a write shows on out from the cycle after the edge (read-before-write within the write cycle).
REQ-019 Address has exactly AW bits; every value is valid; no wrap or out-of-range case exists.
REQ-020 READY persists until rst_n is sampled low; memory holds contents indefinitely.

Reset
REQ-021 rst_n=0 at rising edge -> state CLEAR, clr_ptr=0, busy=1 from next cycle; memory not cleared in that cycle.
REQ-022 Clearing starts on the first edge with rst_n=1; while rst_n is held low, no memory writes occur and busy stays 1.
REQ-023 rst_n low mid-CLEAR restarts the sequence from clr_ptr=0; a full DEPTH cycles follow release.
REQ-024 rst_n low in READY with load=1 -> the write is dropped.
REQ-025 Output values under reset: busy=1, out=0.

Configuration
REQ-026 Macro RAM_N_REGOUT_EN selects registered read.
REQ-027 Defined: out is a register loaded with mem[address] each READY edge (pre-write value when load=1); 1-cycle read latency; register forced to 0 under reset and in CLEAR.
REQ-028 Undefined: combinational read per REQ-018; no output register present.

Verification
REQ-029 WIDTH=16, DEPTH=8: hold rst_n=0 3 cycles, release -> busy=1 exactly 8 cycles, then 0; reading addresses 0..7 returns 0x0000.
REQ-030 READY: write 0xBEEF@3, 0x1234@7; read 3 -> 0xBEEF, 7 -> 0x1234, 5 -> 0x0000; with RAM_N_REGOUT_EN, each value appears one cycle after the address is applied.
REQ-031 load=1, in=0xFFFF, address=2 during CLEAR -> after busy falls, mem[2] reads 0x0000.
REQ-032 Pulse rst_n=0 at clear cycle 4 -> busy stays high a further 8 cycles after release; all words read 0.
REQ-033 WIDTH=8, DEPTH=32: write address k with k^0xA5 for k=0..31, read back all 32 -> match; busy clear time is 32 cycles.
REQ-034 Write 0x00AA@1 then same-cycle read address 1 -> out shows old value that cycle (combinational) or next cycle (registered); 0x00AA on the following read.
